// File: rtl/mux11_arbiter_pkg.sv
// Shared definitions for the two-input four-phase token arbiter.
//   state_t  : FSM state encoding (IDLE=0, ACK_IN=1, SEND=2, RELEASE=3)
//   SEL_IN1  : select value for input 1
//   SEL_IN2  : select value for input 2
package mux11_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK_IN  = 2'd1,
    SEND    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic SEL_IN1 = 1'b0;
  localparam logic SEL_IN2 = 1'b1;

endpackage

// File: rtl/mux11_arbiter_rr_pick2.sv
// Two-way round-robin grant picker (purely combinational).
//   req1, req2  : pending requests from in1 / in2
//   last        : input served most recently (SEL_IN1 / SEL_IN2)
//   grant_valid : at least one request is pending
//   grant_sel   : chosen input; on a tie, the one not served last
module rr_pick2
  import mux11_arbiter_pkg::*;
(
  input  logic req1,
  input  logic req2,
  input  logic last,
  output logic grant_valid,
  output logic grant_sel
);

  always_comb begin
    grant_valid = req1 | req2;
    grant_sel   = SEL_IN1;
    if (req1 && req2) begin
      grant_sel = (last == SEL_IN1) ? SEL_IN2 : SEL_IN1;
    end else if (req2) begin
      grant_sel = SEL_IN2;
    end
  end

endmodule

// File: rtl/mux11_arbiter.sv
// Two-input four-phase token arbiter/mux with registered outputs.
//   clk, reset          : clock, synchronous active-high reset
//   in1_req/data/ack    : input 1 four-phase channel
//   in2_req/data/ack    : input 2 four-phase channel
//   out_req/data/ack    : output four-phase channel
//   out_sel             : source of the current output token (0 = in1, 1 = in2)
//   busy                : high whenever the FSM is not in IDLE
module mux11_arbiter
  import mux11_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in1_req,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ack,
  input  logic             in2_req,
  input  logic [WIDTH-1:0] in2_data,
  output logic             in2_ack,
  output logic             out_req,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ack,
  output logic             busy
);

  // Pointer starts on the input that should lose the first tie.
  localparam logic LAST_INIT = (FIRST == 0) ? SEL_IN2 : SEL_IN1;

  state_t state;
  logic   last;
  logic   grant_valid;
  logic   grant_sel;
  logic   granted_req;

  rr_pick2 u_pick (
    .req1        (in1_req),
    .req2        (in2_req),
    .last        (last),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  // out_sel holds the granted input for the whole handshake.
  always_comb begin
    granted_req = (out_sel == SEL_IN2) ? in2_req : in1_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      in1_ack  <= 1'b0;
      in2_ack  <= 1'b0;
      out_req  <= 1'b0;
      out_data <= '0;
      out_sel  <= SEL_IN1;
      busy     <= 1'b0;
      last     <= LAST_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            out_data <= (grant_sel == SEL_IN2) ? in2_data : in1_data;
            out_sel  <= grant_sel;
            in1_ack  <= (grant_sel == SEL_IN1);
            in2_ack  <= (grant_sel == SEL_IN2);
            busy     <= 1'b1;
            state    <= ACK_IN;
          end
        end
        ACK_IN: begin
          if (!granted_req) begin
            in1_ack <= 1'b0;
            in2_ack <= 1'b0;
            out_req <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (out_ack) begin
            out_req <= 1'b0;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          if (!out_ack) begin
            last  <= out_sel;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux11_arbiter.sv
// Self-checking bench for mux11_arbiter: directed scenarios plus randomized
// traffic, scored against per-source token queues and a tie-alternation model.
module tb_mux11_arbiter;

  localparam int unsigned W = 11;

  logic         clk = 1'b0;
  logic         reset;
  logic         in1_req, in2_req, out_ack;
  logic [W-1:0] in1_data, in2_data;
  logic         in1_ack, in2_ack, out_req, out_sel, busy;
  logic [W-1:0] out_data;

  always #5 clk = ~clk;

  mux11_arbiter #(.WIDTH(11), .FIRST(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .in1_req  (in1_req),
    .in1_data (in1_data),
    .in1_ack  (in1_ack),
    .in2_req  (in2_req),
    .in2_data (in2_data),
    .in2_ack  (in2_ack),
    .out_req  (out_req),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ack  (out_ack),
    .busy     (busy)
  );

  int compared   = 0;
  int mismatched = 0;

  // Tokens waiting to be offered, tokens acked by the DUT, delivered log.
  logic [W-1:0] pend1[$], pend2[$];
  logic [W-1:0] acc1[$], acc2[$];
  logic [W-1:0] data_log[$];
  logic         sel_log[$];

  int   cyc = 0, raise_cyc1 = 0;
  int   gap1 = 0, gap2 = 0, cwait = 0, cons_delay = 0;
  int   tot_acc = 0, tot_del = 0;
  bit   rand_mode = 0, lat_chk = 0, stall_chk = 0, seen_ack2 = 0;
  logic         prev_out_req = 1'b0;
  logic [W-1:0] prev_out_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic deliver();
    logic [W-1:0] e;
    data_log.push_back(out_data);
    sel_log.push_back(out_sel);
    tot_del++;
    if (out_sel == 1'b0) begin
      if (acc1.size() == 0) chk("orphan_in1", 1, 0);
      else begin e = acc1.pop_front(); chk("data_in1", out_data, e); end
    end else begin
      if (acc2.size() == 0) chk("orphan_in2", 1, 0);
      else begin e = acc2.pop_front(); chk("data_in2", out_data, e); end
    end
  endtask

  // One clock cycle of environment: monitors, consumer and both producers.
  task automatic tick();
    @(negedge clk);
    cyc++;
    chk("ack_excl", 32'(in1_ack & in2_ack), 0);
    if (in2_ack) seen_ack2 = 1;
    if (reset) begin
      out_ack = 1'b0;
      cwait   = 0;
      acc1.delete();
      acc2.delete();
    end else begin
      if (prev_out_req && out_req) chk("out_hold", out_data, prev_out_data);
      if (stall_chk && out_req && !out_ack) begin
        chk("stall_busy", busy, 1);
        chk("stall_acks", {in1_ack, in2_ack}, 0);
      end
      // consumer
      if (out_req && !prev_out_req)
        cwait = rand_mode ? int'($urandom_range(0, 3)) : cons_delay;
      if (out_req && !out_ack) begin
        if (cwait == 0) begin out_ack = 1'b1; deliver(); end
        else cwait--;
      end else if (!out_req && out_ack) begin
        out_ack = 1'b0;
      end
      // producer acceptance
      if (in1_req && in1_ack) begin
        if (lat_chk) chk("ack_lat1", cyc - raise_cyc1, 1);
        in1_req = 1'b0; acc1.push_back(in1_data); tot_acc++;
        gap1 = rand_mode ? int'($urandom_range(0, 4)) : 0;
      end
      if (in2_req && in2_ack) begin
        in2_req = 1'b0; acc2.push_back(in2_data); tot_acc++;
        gap2 = rand_mode ? int'($urandom_range(0, 4)) : 0;
      end
    end
    // producer offer (allowed while reset is held)
    if (!in1_req && !in1_ack) begin
      if (gap1 > 0) gap1--;
      else if (pend1.size() > 0) begin
        in1_data = pend1.pop_front(); in1_req = 1'b1; raise_cyc1 = cyc;
      end
    end
    if (!in2_req && !in2_ack) begin
      if (gap2 > 0) gap2--;
      else if (pend2.size() > 0) begin
        in2_data = pend2.pop_front(); in2_req = 1'b1;
      end
    end
    prev_out_req  = out_req;
    prev_out_data = out_data;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(pend1.size() == 0 && pend2.size() == 0 && !in1_req && !in2_req &&
             !in1_ack && !in2_ack && !out_req && !out_ack && !busy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) chk("idle_timeout", 1, 0);
  endtask

  task automatic clear_logs();
    sel_log.delete();
    data_log.delete();
  endtask

  initial begin
    logic         exp_sel;
    logic [W-1:0] tok;
    int           n;

    reset = 1'b1; in1_req = 1'b0; in2_req = 1'b0; out_ack = 1'b0;
    in1_data = '0; in2_data = '0;

    // Tie held from reset: both inputs request continuously.
    for (int unsigned i = 0; i < 2; i++) begin
      pend1.push_back(11'b11111011111);
      pend2.push_back(11'b00000100000);
    end
    tick(); tick(); tick();
    chk("rst_in1_ack",  in1_ack, 0);
    chk("rst_in2_ack",  in2_ack, 0);
    chk("rst_out_req",  out_req, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel",  out_sel, 0);
    chk("rst_busy",     busy, 0);
    chk("tie_reqs_up",  {in1_req, in2_req}, 2'b11);
    reset = 1'b0;
    wait_idle(200);
    chk("tie_count", sel_log.size(), 4);
    exp_sel = 1'b0;
    for (int i = 0; i < sel_log.size(); i++) begin
      chk("tie_order", sel_log[i], exp_sel);
      exp_sel = ~exp_sel;
    end

    // Single in1 token, zero-delay consumer, ack latency of one cycle.
    clear_logs(); seen_ack2 = 0; lat_chk = 1;
    pend1.push_back(11'b00111000001);
    wait_idle(100);
    lat_chk = 0;
    chk("t1_count", data_log.size(), 1);
    if (data_log.size() == 1) begin
      chk("t1_data", data_log[0], 11'b00111000001);
      chk("t1_sel",  sel_log[0], 0);
    end
    chk("t1_no_ack2", seen_ack2, 0);

    // Two in2 tokens in order.
    clear_logs();
    pend2.push_back(11'b00000000000);
    pend2.push_back(11'b11111000000);
    wait_idle(100);
    chk("t2_count", data_log.size(), 2);
    if (data_log.size() == 2) begin
      chk("t2_data0", data_log[0], 11'b00000000000);
      chk("t2_data1", data_log[1], 11'b11111000000);
      chk("t2_sel0",  sel_log[0], 1);
      chk("t2_sel1",  sel_log[1], 1);
    end

    // Consumer stall of 20 cycles on an in1 token.
    clear_logs(); stall_chk = 1; cons_delay = 20;
    tok = 11'($urandom);
    pend1.push_back(tok);
    wait_idle(200);
    stall_chk = 0; cons_delay = 0;
    chk("stall_count", data_log.size(), 1);
    if (data_log.size() == 1) chk("stall_data", data_log[0], tok);

    // Reset while in SEND, then a tie must go to FIRST again.
    cons_delay = 100;
    pend1.push_back(11'h2a5);
    n = 0;
    while (!out_req && n < 50) begin tick(); n++; end
    chk("send_reached", out_req, 1);
    reset = 1'b1;
    tick();
    chk("rs_out_req", out_req, 0);
    chk("rs_busy",    busy, 0);
    chk("rs_acks",    {in1_ack, in2_ack}, 0);
    reset = 1'b0; cons_delay = 0;
    tick();
    clear_logs();
    pend1.push_back(11'h155);
    pend2.push_back(11'h0f3);
    wait_idle(100);
    chk("rs_count", sel_log.size(), 2);
    if (sel_log.size() == 2) begin
      chk("rs_first_sel",  sel_log[0], 0);
      chk("rs_second_sel", sel_log[1], 1);
      chk("rs_in2_data",   data_log[1], 11'h0f3);
    end

    // Randomized traffic with random gaps and consumer delays.
    rand_mode = 1; tot_acc = 0; tot_del = 0;
    for (int unsigned i = 0; i < 120; i++) begin
      if ($urandom_range(0, 1) == 0) pend1.push_back(11'($urandom));
      else                           pend2.push_back(11'($urandom));
    end
    wait_idle(5000);
    rand_mode = 0;
    chk("rnd_accepted",  tot_acc, 120);
    chk("rnd_delivered", tot_del, 120);
    chk("rnd_leftover",  acc1.size() + acc2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
